// File: rtl/ram_copy_engine.sv
// Copies len words between two ranges of a single-port-read / single-port-write RAM.
// The engine issues one read per cycle and writes each word one cycle later.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; captured values and words_copied held
// ST_READ  | one read per cycle; each write trails its read by a cycle
// ST_DRAIN | no read issued; the final write is on the bus
// ST_DONE  | done pulse for one cycle, then back to idle
module ram_copy_engine #(
  parameter int DEPTH  = 256,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] src_addr,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rd_enbl,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  output logic              wr_enbl,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic [AWIDTH:0]   words_copied
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AWIDTH:0] LEN_MAX = (AWIDTH + 1)'(DEPTH);

  logic [1:0]        state;
  logic [AWIDTH:0]   rd_left;
  logic [AWIDTH:0]   len_clip;
  logic [AWIDTH-1:0] dst_ptr;

  // A count above the RAM size would only re-copy words; saturate it.
  assign len_clip = (len > LEN_MAX) ? LEN_MAX : len;

  // Read data arrives the cycle the matching write is on the bus.
  assign wr_data = rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_enbl      <= 1'b0;
      rd_addr      <= '0;
      wr_enbl      <= 1'b0;
      wr_addr      <= '0;
      words_copied <= '0;
      rd_left      <= '0;
      dst_ptr      <= '0;
    end else begin
      done    <= 1'b0;
      wr_enbl <= rd_enbl;

      // Every issued read schedules a write to the next destination word.
      if (rd_enbl) begin
        wr_addr <= dst_ptr;
        dst_ptr <= dst_ptr + 1'b1;
      end

      if (wr_enbl) begin
        words_copied <= words_copied + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            dst_ptr      <= dst_addr;
            rd_addr      <= src_addr;
            words_copied <= '0;
            if (len_clip == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_READ;
              busy    <= 1'b1;
              rd_enbl <= 1'b1;
              rd_left <= len_clip - 1'b1;
            end
          end
        end

        ST_READ: begin
          if (rd_left == '0) begin
            rd_enbl <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            rd_left <= rd_left - 1'b1;
          end
        end

        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural RAM (old data on
// read-during-write) and a monitor that logs every RAM access and done pulse.
module tb_ram_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] len;
  logic       busy;
  logic       done;
  logic       rd_enbl;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_enbl;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [8:0] words_copied;

  logic       preload;
  logic       clr;
  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  logic [7:0] rd_log  [16];
  logic [7:0] wr_log  [16];
  logic [7:0] wd_log  [16];

  int cyc = 0;
  int rd_count, wr_count, done_count;
  int first_rd, last_wr, done_edge;
  logic busy_seen;
  int t_acc;
  int n_chk = 0;
  int n_err = 0;

  ram_copy_engine #(.DEPTH(256), .DWIDTH(8), .AWIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .rd_enbl      (rd_enbl),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_enbl      (wr_enbl),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .words_copied (words_copied)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else begin
      if (wr_enbl) mem[wr_addr] <= wr_data;
      if (rd_enbl) rd_data <= mem[rd_addr];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      rd_count   <= 0;
      wr_count   <= 0;
      done_count <= 0;
      first_rd   <= -1;
      last_wr    <= -1;
      done_edge  <= -1;
      busy_seen  <= 1'b0;
    end else begin
      if (rd_enbl) begin
        if (rd_count < 16) rd_log[rd_count] <= rd_addr;
        if (rd_count == 0) first_rd <= cyc;
        rd_count <= rd_count + 1;
      end
      if (wr_enbl) begin
        if (wr_count < 16) begin
          wr_log[wr_count] <= wr_addr;
          wd_log[wr_count] <= wr_data;
        end
        wr_count <= wr_count + 1;
        last_wr  <= cyc;
      end
      if (done) begin
        done_count <= done_count + 1;
        done_edge  <= cyc;
      end
      if (busy) busy_seen <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc - 1;
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && done_count == 0; k++) @(negedge clk);
    @(negedge clk);
    check_val("done_seen", done_count, 1);
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check_val(tag, bad, 0);
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1; clr = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    rst = 1'b0; preload = 1'b0; clr = 1'b0;
    @(negedge clk);

    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_rd_enbl", int'(rd_enbl), 0);
    check_val("rst_wr_enbl", int'(wr_enbl), 0);
    check_val("rst_rd_addr", int'(rd_addr), 0);
    check_val("rst_wr_addr", int'(wr_addr), 0);
    check_val("rst_words", int'(words_copied), 0);

    // basic copy
    start_copy(8'h10, 8'h80, 9'd4);
    check_val("basic_busy", int'(busy), 1);
    wait_done(50);
    for (int i = 0; i < 4; i++) exp_mem[8'h80 + i] = 8'(8'h10 + i);
    check_mem("basic_mem");
    check_val("basic_first_rd", first_rd - t_acc, 1);
    check_val("basic_last_wr", last_wr - t_acc, 5);
    check_val("basic_done_lat", done_edge - t_acc, 6);
    check_val("basic_words", int'(words_copied), 4);
    check_val("basic_rd_count", rd_count, 4);
    check_val("basic_wr_count", wr_count, 4);
    check_val("basic_busy_end", int'(busy), 0);

    // address wrap
    start_copy(8'hFE, 8'h01, 9'd3);
    wait_done(50);
    check_val("wrap_rd0", int'(rd_log[0]), 8'hFE);
    check_val("wrap_rd1", int'(rd_log[1]), 8'hFF);
    check_val("wrap_rd2", int'(rd_log[2]), 8'h00);
    check_val("wrap_wa0", int'(wr_log[0]), 8'h01);
    check_val("wrap_wa2", int'(wr_log[2]), 8'h03);
    check_val("wrap_wd0", int'(wd_log[0]), 8'hFE);
    check_val("wrap_wd1", int'(wd_log[1]), 8'hFF);
    check_val("wrap_wd2", int'(wd_log[2]), 8'h00);
    exp_mem[1] = 8'hFE; exp_mem[2] = 8'hFF; exp_mem[3] = 8'h00;
    check_mem("wrap_mem");

    // zero length
    start_copy(8'h05, 8'h06, 9'd0);
    wait_done(20);
    check_val("zero_done_lat", done_edge - t_acc, 1);
    check_val("zero_rd_count", rd_count, 0);
    check_val("zero_wr_count", wr_count, 0);
    check_val("zero_busy_seen", int'(busy_seen), 0);
    check_val("zero_words", int'(words_copied), 0);

    // full RAM onto itself
    start_copy(8'h00, 8'h00, 9'd256);
    wait_done(400);
    check_val("full_rd_count", rd_count, 256);
    check_val("full_wr_count", wr_count, 256);
    check_val("full_done_lat", done_edge - t_acc, 258);
    check_val("full_words", int'(words_copied), 256);
    check_mem("full_mem");

    // reset on the third read of a len=8 copy
    start_copy(8'h20, 8'h40, 9'd8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_rd_enbl", int'(rd_enbl), 0);
    check_val("abort_wr_enbl", int'(wr_enbl), 0);
    check_val("abort_words", int'(words_copied), 0);
    repeat (12) @(negedge clk);
    check_val("abort_wr_count", wr_count, 2);
    check_val("abort_done_count", done_count, 0);
    exp_mem[8'h40] = 8'h20; exp_mem[8'h41] = 8'h21;
    check_mem("abort_mem");

    // reset wins over a simultaneous start
    @(negedge clk);
    src_addr = 8'h00; dst_addr = 8'hC0; len = 9'd4;
    rst = 1'b1; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; clr = 1'b0;
    repeat (8) @(negedge clk);
    check_val("rststart_rd_count", rd_count, 0);
    check_val("rststart_busy_seen", int'(busy_seen), 0);

    // start pulses while busy and while in DONE are ignored
    start_copy(8'h30, 8'h90, 9'd6);
    @(negedge clk);
    @(negedge clk);
    src_addr = 8'h00; dst_addr = 8'hF0; len = 9'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30 && done !== 1'b1; k++) @(negedge clk);
    check_val("ign_done_vis", int'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("ign_busy_after_done", int'(busy), 0);
    repeat (6) @(negedge clk);
    check_val("ign_done_count", done_count, 1);
    check_val("ign_done_lat", done_edge - t_acc, 8);
    check_val("ign_rd_count", rd_count, 6);
    check_val("ign_wr_count", wr_count, 6);
    check_val("ign_words", int'(words_copied), 6);
    for (int i = 0; i < 6; i++) exp_mem[8'h90 + i] = 8'(8'h30 + i);
    check_mem("ign_mem");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_copy_engine.md
RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

Interface
REQ-001 Parameter DEPTH, default 256: number of RAM words addressed.
REQ-002 Parameter DWIDTH, default 8: RAM data width in bits.
REQ-003 Parameter AWIDTH, default 8: address width; DEPTH SHALL equal 2**AWIDTH.
REQ-004 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: request a copy; sampled only in IDLE.
REQ-007 Port src_addr, input, AWIDTH: first source address, captured on an accepted start.
REQ-008 Port dst_addr, input, AWIDTH: first destination address, captured on an accepted start.
REQ-009 Port len, input, AWIDTH+1: word count, 0..DEPTH, captured on an accepted start.
REQ-010 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-011 Port done, output, 1: one-cycle pulse when a copy completes.
REQ-012 Port rd_enbl, output, 1: RAM read enable.
REQ-013 Port rd_addr, output, AWIDTH: RAM read address.
REQ-014 Port rd_data, input, DWIDTH: RAM read data, valid exactly 1 cycle after rd_enbl is sampled high.
REQ-015 Port wr_enbl, output, 1: RAM write enable.
REQ-016 Port wr_addr, output, AWIDTH: RAM write address.
REQ-017 Port wr_data, output, DWIDTH: RAM write data.
REQ-018 Port words_copied, output, AWIDTH+1: count of writes issued in the current or last copy.

Function
REQ-019 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-020 IDLE with start=1 SHALL capture src_addr, dst_addr and len, clear words_copied, and go to READ, or go to DONE if len=0.
REQ-021 READ SHALL assert rd_enbl every cycle, with rd_addr = (src + i) mod DEPTH for i = 0..len-1, one read per cycle with no gaps.
REQ-022 A write SHALL be issued in the cycle after each read: wr_enbl=1, wr_addr = (dst + i) mod DEPTH, wr_data = rd_data (combinational pass-through, no extra register).
REQ-023 After issuing read len-1, READ SHALL go to DRAIN; DRAIN SHALL issue the final write and go to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE; busy SHALL be low in DONE and in IDLE.
REQ-025 Latency: for len=N>0, accept at edge T, first rd_enbl at T+1, last wr_enbl at T+N+1, done at T+N+2.
REQ-026 For len=0, there SHALL be no rd_enbl and no wr_enbl, and done SHALL occur at T+1.
REQ-027 Address counters SHALL wrap modulo DEPTH, so 255 is followed by 0.
REQ-028 len=DEPTH (256) SHALL copy all words, with exactly 256 reads and 256 writes.
REQ-029 start while busy, or while in DONE, SHALL be ignored and SHALL NOT disturb captured values.
REQ-030 words_copied SHALL increment on every wr_enbl cycle and hold its final value until the next accepted start.
REQ-031 Overlapping ranges SHALL NOT be corrected for. dst[i] receives the RAM content of src+i at the cycle its read is issued, and RAM read-during-write at the same address returns old data.
REQ-032 When not in the state that asserts them, rd_enbl and wr_enbl SHALL be 0, and rd_addr, wr_addr and wr_data SHALL hold their last values.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE. The same edge SHALL clear busy, done, rd_enbl, wr_enbl, rd_addr, wr_addr and words_copied to 0. wr_data is not registered and follows rd_data.
REQ-034 Reset during READ or DRAIN SHALL abort the copy with no further RAM accesses; partial writes already issued remain in RAM.
REQ-035 rst=1 together with start=1 SHALL give reset priority; the start is discarded.

Verification
REQ-036 Preload RAM[i]=i. Start with src=0x10, dst=0x80, len=4 → RAM[0x80..0x83]=0x10..0x13, done at T+6, words_copied=4.
REQ-037 Wrap test: src=0xFE, dst=0x01, len=3 → reads 0xFE, 0xFF, 0x00 and writes 0x01..0x03 with data 0xFE, 0xFF, 0x00.
REQ-038 len=0 → no RAM enables, done at T+1, busy never high, words_copied=0.
REQ-039 len=256 with src=0 and dst=0 → 256 reads and 256 writes, RAM unchanged, words_copied=256.
REQ-040 Assert rst for 1 cycle on the third read of a len=8 copy → next cycle state is IDLE, all enables are 0, no done pulse, and only 2 writes have occurred.
REQ-041 Pulse start again mid-copy with different src/dst/len → ignored, and the original copy completes unchanged.
